// File: rtl/conv_layer_sched_if.sv
// Bus bundle between the conv layer scheduler (master) and its weight ROM,
// feature buffer, conv datapath and result buffer (slave side).
interface conv_layer_sched_if;
  // Handshake semantics: no backpressure anywhere. A read strobe (wt_rd_en,
  // fm_rd_en) with its address is sampled on a rising edge and the memory
  // returns rdata during the following cycle. conv_ovalid, res_wr_en,
  // layer_done and done are single-cycle qualifiers valid in the cycle they
  // are high. Pixels are two's complement and forwarded untouched.
  logic        go;
  logic        wt_rd_en;
  logic [5:0]  wt_addr;
  logic        wt_rdata;
  logic        fm_rd_en;
  logic [9:0]  fm_addr;
  logic [31:0] fm_rdata;
  logic        conv_start;
  logic        conv_weight_en;
  logic        conv_weight;
  logic        conv_state;
  logic [31:0] conv_din;
  logic        conv_ovalid;
  logic [31:0] conv_dout;
  logic        res_wr_en;
  logic [7:0]  res_addr;
  logic [31:0] res_data;
  logic        layer_done;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    input  go, wt_rdata, fm_rdata, conv_ovalid, conv_dout,
    output wt_rd_en, wt_addr, fm_rd_en, fm_addr, conv_start, conv_weight_en,
           conv_weight, conv_state, conv_din, res_wr_en, res_addr, res_data,
           layer_done, done, busy, err
  );

  modport slave (
    output go, wt_rdata, fm_rdata, conv_ovalid, conv_dout,
    input  wt_rd_en, wt_addr, fm_rd_en, fm_addr, conv_start, conv_weight_en,
           conv_weight, conv_state, conv_din, res_wr_en, res_addr, res_data,
           layer_done, done, busy, err
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Two-layer conv scheduler: loads binary weights, streams pixels, collects pooled results.
// Optional RUN watchdog enabled by defining CONV_SCHED_WDOG_EN.
module conv_layer_sched #(
  parameter int W_BITS = 25,
  parameter int L0_PIX = 784,
  parameter int L0_OUT = 144,
  parameter int L1_PIX = 144,
  parameter int L1_OUT = 16
) (
  input  logic               clk,
  input  logic               rstn,
  conv_layer_sched_if.master bus,
  output logic [2:0]         dbg_state_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_PRIME, S_RUN, S_LAYER_END, S_FINISH
  } state_t;

  localparam logic [4:0] W_LAST   = 5'(W_BITS - 1);
  localparam logic [9:0] L0_PIX_C = 10'(L0_PIX);
  localparam logic [9:0] L1_PIX_C = 10'(L1_PIX);
  localparam logic [7:0] L0_LAST  = 8'(L0_OUT - 1);
  localparam logic [7:0] L1_LAST  = 8'(L1_OUT - 1);

  state_t      state_q, state_d;
  logic        layer_q, layer_d;
  logic [4:0]  bit_q, bit_d;
  logic [9:0]  pix_q, pix_d;
  logic [7:0]  out_q, out_d;
  logic        wt_en_q, fm_en_q;
  logic        wt_rd, fm_rd, res_wr, ld_pulse, done_pulse;
  logic [9:0]  fm_addr;
  logic [9:0]  pix_lim;
  logic [7:0]  out_last;
  logic        wd_trip;

`ifdef CONV_SCHED_WDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'd4095;
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  // The counter parks at the limit after a trip, so LAYER_END can tell an abort apart.
  assign wd_trip = (wd_q == WD_LIMIT);
`else
  assign wd_trip = 1'b0;
`endif

  assign pix_lim  = layer_q ? L1_PIX_C : L0_PIX_C;
  assign out_last = layer_q ? L1_LAST : L0_LAST;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      layer_q <= 1'b0;
      bit_q   <= '0;
      pix_q   <= '0;
      out_q   <= '0;
      wt_en_q <= 1'b0;
      fm_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      wt_en_q <= wt_rd;
      fm_en_q <= fm_rd;
    end
  end

`ifdef CONV_SCHED_WDOG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    bit_d      = bit_q;
    pix_d      = pix_q;
    out_d      = out_q;
    wt_rd      = 1'b0;
    fm_rd      = 1'b0;
    fm_addr    = '0;
    res_wr     = 1'b0;
    ld_pulse   = 1'b0;
    done_pulse = 1'b0;
`ifdef CONV_SCHED_WDOG_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_LOAD_W;
          layer_d = 1'b0;
          bit_d   = '0;
          pix_d   = '0;
          out_d   = '0;
        end
      end
      S_LOAD_W: begin
        wt_rd = 1'b1;
        bit_d = bit_q + 5'd1;
        if (bit_q == W_LAST) begin
          bit_d   = '0;
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        // Pixel 0 is fetched here so it is on conv_din as conv_start rises.
        fm_rd   = 1'b1;
        pix_d   = 10'd1;
        state_d = S_RUN;
`ifdef CONV_SCHED_WDOG_EN
        wd_d    = '0;
`endif
      end
      S_RUN: begin
        if (pix_q < pix_lim) begin
          fm_rd   = 1'b1;
          fm_addr = pix_q;
          pix_d   = pix_q + 10'd1;
        end
        if (bus.conv_ovalid) begin
          res_wr = 1'b1;
          out_d  = out_q + 8'd1;
          if (out_q == out_last) state_d = S_LAYER_END;
        end
`ifdef CONV_SCHED_WDOG_EN
        if (bus.conv_ovalid) begin
          wd_d = '0;
        end else if (wd_trip) begin
          err_d   = 1'b1;
          state_d = S_LAYER_END;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      S_LAYER_END: begin
        ld_pulse = 1'b1;
        pix_d    = '0;
        out_d    = '0;
        bit_d    = '0;
        if (!layer_q && !wd_trip) begin
          layer_d = 1'b1;
          state_d = S_LOAD_W;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_pulse = 1'b1;
        layer_d    = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.wt_rd_en       = wt_rd;
  assign bus.wt_addr        = wt_rd ? {layer_q, bit_q} : 6'd0;
  assign bus.fm_rd_en       = fm_rd;
  assign bus.fm_addr        = fm_addr;
  assign bus.conv_start     = (state_q == S_RUN);
  assign bus.conv_weight_en = wt_en_q;
  assign bus.conv_weight    = wt_en_q & bus.wt_rdata;
  assign bus.conv_state     = layer_q;
  assign bus.conv_din       = fm_en_q ? bus.fm_rdata : 32'd0;
  assign bus.res_wr_en      = res_wr;
  assign bus.res_addr       = out_q;
  assign bus.res_data       = res_wr ? bus.conv_dout : 32'd0;
  assign bus.layer_done     = ld_pulse;
  assign bus.done           = done_pulse;
  assign bus.busy           = (state_q != S_IDLE);
`ifdef CONV_SCHED_WDOG_EN
  assign bus.err            = err_q;
`else
  assign bus.err            = 1'b0;
`endif
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: IDLE vector table, full randomized runs against a
// memory/datapath model with result scoreboard, mid-run reset, optional watchdog.
module tb_conv_layer_sched;
  logic       clk;
  logic       rstn;
  logic [2:0] dbg_state;

  conv_layer_sched_if bus ();

  conv_layer_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / global timeout ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- shared state ----------------
  int errors = 0;
  int checks = 0;

  logic        wt_mem [64];
  logic [31:0] fm_mem [1024];
  logic [39:0] exp_q [$];
  logic [5:0]  exp_wt_q [$];

  logic        mon_en = 1'b0;
  logic        wdog_mode = 1'b0;
  logic        stray_req = 1'b0;
  int          lim0 = 144;
  int          lim1 = 16;
  int          n_wr = 0;
  int          fm_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int pix_of(input logic layer);
    return layer ? 144 : 784;
  endfunction

  // ---------------- memory and datapath models ----------------
  logic       wt_ren_s, fm_ren_s, dp_start_s, dp_layer_s;
  logic [5:0] wt_addr_s;
  logic [9:0] fm_addr_s;
  int         emitted = 0;
  int         run_cyc = 0;

  always @(negedge clk) begin
    wt_ren_s   = bus.wt_rd_en;
    wt_addr_s  = bus.wt_addr;
    fm_ren_s   = bus.fm_rd_en;
    fm_addr_s  = bus.fm_addr;
    dp_start_s = bus.conv_start;
    dp_layer_s = bus.conv_state;
  end

  always @(posedge clk) begin
    #1;
    if (wt_ren_s) bus.wt_rdata = wt_mem[wt_addr_s];
  end

  always @(posedge clk) begin
    #1;
    if (fm_ren_s) bus.fm_rdata = fm_mem[fm_addr_s];
  end

  // Datapath: after a short latency, results arrive at random gaps; result k
  // of a layer must land at res_addr k with the emitted data.
  always @(posedge clk) begin
    logic stray_s;
    stray_s = stray_req;
    #1;
    bus.conv_ovalid = 1'b0;
    if (!dp_start_s) begin
      emitted = 0;
      run_cyc = 0;
    end else begin
      run_cyc++;
      if (run_cyc > 3 && emitted < (dp_layer_s ? lim1 : lim0) && $urandom_range(0, 2) == 0) begin
        bus.conv_ovalid = 1'b1;
        bus.conv_dout   = $urandom;
        exp_q.push_back({8'(emitted), bus.conv_dout});
        emitted++;
      end
    end
    if (stray_s) begin
      bus.conv_ovalid = 1'b1;
      bus.conv_dout   = $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       p_wt_rd = 1'b0, p_fm_rd = 1'b0, p_start = 1'b0, p_res_wr = 1'b0;
  logic [5:0] p_wt_addr = '0;
  logic [9:0] p_fm_addr = '0;

  always @(negedge clk) begin
    logic [39:0] e;
    if (mon_en) begin
      if (bus.res_wr_en) begin
        n_wr++;
        if (exp_q.size() == 0) chk("res_wr_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("res_addr", bus.res_addr, e[39:32]);
          chk("res_data", bus.res_data, e[31:0]);
        end
      end
      if (bus.wt_rd_en) begin
        if (exp_wt_q.size() == 0) chk("wt_rd_extra", 1, 0);
        else chk("wt_addr", bus.wt_addr, exp_wt_q.pop_front());
        chk("conv_state_vs_wt_layer", bus.conv_state, bus.wt_addr[5]);
      end
      chk("conv_weight_en_lag", bus.conv_weight_en, p_wt_rd);
      if (p_wt_rd) chk("conv_weight", bus.conv_weight, wt_mem[p_wt_addr]);
      if (bus.fm_rd_en) begin
        chk("fm_addr", bus.fm_addr, fm_exp);
        chk("fm_addr_range", bus.fm_addr < pix_of(bus.conv_state), 1);
        fm_exp++;
      end
      if (p_fm_rd) chk("conv_din", bus.conv_din, fm_mem[p_fm_addr]);
      else if (bus.conv_start) chk("conv_din_zero", bus.conv_din, 0);
      if (bus.conv_start && !p_start) chk("prime_before_start", {p_fm_rd, p_fm_addr == 10'd0}, 2'b11);
      if (!bus.conv_start && p_start && !wdog_mode) begin
        chk("last_write_before_stop", p_res_wr, 1);
        chk("layer_done_at_stop", bus.layer_done, 1);
      end
      if (bus.layer_done) fm_exp = 0;
    end
    p_wt_rd   = bus.wt_rd_en;
    p_wt_addr = bus.wt_addr;
    p_fm_rd   = bus.fm_rd_en;
    p_fm_addr = bus.fm_addr;
    p_start   = bus.conv_start;
    p_res_wr  = bus.res_wr_en;
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.busy, bus.wt_rd_en, bus.fm_rd_en, bus.conv_start, bus.conv_weight_en,
                         bus.conv_weight, bus.conv_state, bus.res_wr_en, bus.layer_done, bus.done,
                         bus.err}, 0);
    chk({tag, "_addr"}, {bus.wt_addr, bus.fm_addr, bus.res_addr}, 0);
    chk({tag, "_din"}, bus.conv_din, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic start_run();
    exp_wt_q.delete();
    for (int i = 0; i < 25; i++) exp_wt_q.push_back(6'(i));
    for (int i = 0; i < 25; i++) exp_wt_q.push_back(6'(32 + i));
    fm_exp = 0;
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic full_run();
    int ld;
    int cyc;
    int base;
    base = n_wr;
    start_run();
    ld  = 0;
    cyc = 0;
    while (ld < 2 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.layer_done) ld++;
      bus.go = (ld < 2) && bus.conv_start && ($urandom_range(0, 149) == 0);
    end
    chk("layer_done_count", ld, 2);
    bus.go = 1'b1;
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    chk("busy_in_finish", bus.busy, 1);
    @(negedge clk);
    bus.go = 1'b0;
    chk("busy_after_done", bus.busy, 0);
    chk("done_single", bus.done, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stay_idle", {bus.busy, bus.conv_state, bus.wt_rd_en}, 0);
    end
    chk("writes_total", n_wr - base, 160);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("weights_all_read", exp_wt_q.size(), 0);
    chk("err_low", bus.err, 0);
  endtask

  // ---------------- IDLE vector table ----------------
  typedef struct {
    logic       go;
    logic       stray;
    logic       exp_busy;
    logic       exp_wt_rd;
    logic [5:0] exp_wt_addr;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int base;
    vecs[0] = '{go: 1'b0, stray: 1'b0, exp_busy: 1'b0, exp_wt_rd: 1'b0, exp_wt_addr: 6'd0};
    vecs[1] = '{go: 1'b0, stray: 1'b1, exp_busy: 1'b0, exp_wt_rd: 1'b0, exp_wt_addr: 6'd0};
    vecs[2] = '{go: 1'b1, stray: 1'b0, exp_busy: 1'b1, exp_wt_rd: 1'b1, exp_wt_addr: 6'd0};
    vecs[3] = '{go: 1'b1, stray: 1'b1, exp_busy: 1'b1, exp_wt_rd: 1'b1, exp_wt_addr: 6'd0};
    vecs[4] = '{go: 1'b0, stray: 1'b1, exp_busy: 1'b0, exp_wt_rd: 1'b0, exp_wt_addr: 6'd0};
    vecs[5] = '{go: 1'b1, stray: 1'b0, exp_busy: 1'b1, exp_wt_rd: 1'b1, exp_wt_addr: 6'd0};
    for (int i = 0; i < 64; i++) wt_mem[i] = 1'($urandom);
    for (int i = 0; i < 1024; i++) fm_mem[i] = $urandom;

    rstn   = 1'b0;
    bus.go = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.go    = vecs[i].go;
      stray_req = vecs[i].stray;
      @(negedge clk);
      bus.go    = 1'b0;
      stray_req = 1'b0;
      chk("vec_busy", bus.busy, vecs[i].exp_busy);
      chk("vec_wt_rd", bus.wt_rd_en, vecs[i].exp_wt_rd);
      chk("vec_wt_addr", bus.wt_addr, vecs[i].exp_wt_addr);
      chk("vec_no_write", bus.res_wr_en, 0);
      if (bus.busy) do_reset();
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    mon_en = 1'b1;

    full_run();

    base = n_wr;
    start_run();
    cyc = 0;
    while (n_wr - base < 70 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_output_70", n_wr - base >= 70, 1);
    chk("reset_in_run", bus.conv_start, 1);
    #2;
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.delete();
    exp_wt_q.delete();
    fm_exp = 0;
    @(negedge clk);
    mon_en = 1'b1;

    full_run();

`ifdef CONV_SCHED_WDOG_EN
    begin
      logic seen_done;
      wdog_mode = 1'b1;
      lim0      = 10;
      base      = n_wr;
      start_run();
      seen_done = 1'b0;
      cyc       = 0;
      while (!seen_done && cyc < 6000) begin
        @(negedge clk);
        cyc++;
        if (bus.done) seen_done = 1'b1;
      end
      chk("wdog_done", seen_done, 1);
      chk("wdog_err", bus.err, 1);
      chk("wdog_writes", n_wr - base, 10);
      chk("wdog_waited", cyc > 4095, 1);
      @(negedge clk);
      chk("wdog_idle", bus.busy, 0);
      chk("wdog_err_sticky", bus.err, 1);
      mon_en = 1'b0;
      do_reset();
      @(negedge clk);
      chk("wdog_err_cleared", bus.err, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_layer_sched.md
CONV_LAYER_SCHED -- requirements
Module: conv_layer_sched

Interface
REQ-001 Parameter W_BITS, 25, binary weight bits per layer (5x5 kernel).
REQ-002 Parameter L0_PIX, 784, input pixels streamed in layer 0 (28x28).
REQ-003 Parameter L0_OUT, 144, pooled outputs expected in layer 0.
REQ-004 Parameter L1_PIX, 144, input pixels streamed in layer 1 (12x12).
REQ-005 Parameter L1_OUT, 16, pooled outputs expected in layer 1.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 go  in  1  single-cycle request to run both layers; honoured only in IDLE.
REQ-009 wt_rd_en / wt_addr  out  1 / 6  weight ROM read strobe and address {layer, bit index}; rdata valid next cycle.
REQ-010 wt_rdata  in  1  weight ROM data.
REQ-011 fm_rd_en / fm_addr  out  1 / 10  feature buffer read strobe and pixel address; rdata valid next cycle.
REQ-012 fm_rdata  in  32  signed pixel from feature buffer.
REQ-013 conv_start, conv_weight_en, conv_weight, conv_state  out  1 each  drive conv datapath start, weight_en, weight, state.
REQ-014 conv_din  out  32  signed pixel to conv datapath.
REQ-015 conv_ovalid / conv_dout  in  1 / 32  pooled result from conv datapath.
REQ-016 res_wr_en / res_addr / res_data  out  1 / 8 / 32  result buffer write port.
REQ-017 layer_done  out  1  one-cycle pulse at end of each layer.
REQ-018 done  out  1  one-cycle pulse after layer 1 completes.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 err  out  1  sticky watchdog error (see Configuration).

Function
REQ-021 FSM states IDLE, LOAD_W, PRIME, RUN, LAYER_END, FINISH; layer register L (0/1) drives conv_state.
REQ-022 IDLE: go -> LOAD_W, L=0; go in any other state ignored.
REQ-023 LOAD_W: wt_rd_en high exactly W_BITS cycles, wt_addr = {L, 0..W_BITS-1}; conv_weight_en = wt_rd_en delayed 1 cycle, conv_weight = wt_rdata; leaves to PRIME after last read.
REQ-024 PRIME: one cycle, issues fm read of address 0 so conv_din is valid when conv_start rises.
REQ-025 RUN: conv_start held high (level) for the entire state; fm_rd_en high, fm_addr increments per cycle until PIX-1 reads issued, then fm_rd_en low and conv_din forced 0.
REQ-026 conv_din = fm_rdata registered path, 1-cycle after fm_rd_en; latency pixel-read to conv_din is 1 cycle.
REQ-027 Each conv_ovalid in RUN: res_wr_en=1, res_data=conv_dout, res_addr = running output count (same cycle, combinational from counter); count +1.
REQ-028 conv_ovalid outside RUN ignored, no write.
REQ-029 Count reaching OUT(L) -> LAYER_END; conv_start low the following cycle.
REQ-030 LAYER_END: layer_done pulse 1 cycle; L=0 -> L=1, counters cleared, LOAD_W; L=1 -> FINISH.
REQ-031 FINISH: done pulse 1 cycle, -> IDLE, conv_state returns 0.
REQ-032 res_addr restarts at 0 each layer; output counter 8 bits, never wraps (terminates at OUT).
REQ-033 go coincident with FINISH cycle ignored; new run needs go in IDLE.

Reset
REQ-034 rstn low, at any time including mid-layer: FSM -> IDLE, L=0, all counters 0, every output 0, err cleared.
REQ-035 Deassertion synchronous to clk; first go accepted on the first edge after release.

Configuration
REQ-036 Macro CONV_SCHED_WDOG_EN: when defined, a 16-bit counter clears on entering RUN and on each conv_ovalid; reaching 4095 sets err (sticky), forces LAYER_END path to FINISH with done pulse.
REQ-037 Without CONV_SCHED_WDOG_EN: no watchdog logic, err tied 0, RUN waits indefinitely.

Verification
REQ-038 go after reset -> 25 wt reads addr 0..24, conv_weight_en 25 cycles lagging by 1, then PRIME, conv_start rises.
REQ-039 Layer 0 model returning 144 ovalids -> res_addr 0..143 written, layer_done, layer 1 weights addr 32..56, conv_state=1.
REQ-040 Layer 1 with 16 ovalids -> done pulse once, busy low next cycle, fm_addr never exceeds 143 in layer 1.
REQ-041 rstn pulled low at RUN output 70 -> all outputs 0 immediately; fresh go restarts from weight addr 0.
REQ-042 go pulsed during RUN and during FINISH -> no effect; stray conv_ovalid in IDLE -> no res_wr_en.
REQ-043 With CONV_SCHED_WDOG_EN, datapath model stalls after 10 outputs -> err=1 after 4095 idle cycles, done pulse, IDLE.
